// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - five-stage pipeline enable/flush sequencing, shared memory port arbitration, stall counter
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemreq,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             branch_taken,
  input  logic             jump_id,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             igrant,
  output logic             dgrant,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

  state_t             state_q, state_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;

  logic active;
  logic advance;
  logic load_use;
  logic lu_stall;

  // Memory port arbitration and hazard detection; data side keeps the port until dhit
  always_comb begin
    active   = !RST && (state_q != HALT);
    dgrant   = active && (dmemreq || (state_q == MEMWAIT));
    igrant   = active && !dgrant;
    advance  = active && (dgrant ? dhit : ihit);
    load_use = idex_memread && (idex_rt != 5'd0) &&
               ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    lu_stall = advance && !branch_taken && load_use;
  end

  // Latch enable/flush selection, first matching hazard wins
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (advance) begin
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (branch_taken) begin
        pc_en       = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (jump_id) begin
        pc_en      = 1'b1;
        ifid_flush = 1'b1;
      end else if (dgrant) begin
        // fetch lost the port this cycle, so IF/ID takes a bubble and the PC holds
        ifid_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end
  end

  // Next state, halted flag and saturating stall counter
  always_comb begin
    state_d       = state_q;
    stall_count_d = stall_count_q;
    case (state_q)
      RUN: begin
        if (halt_wb && advance)      state_d = HALT;
        else if (dmemreq && !dhit)   state_d = MEMWAIT;
      end
      MEMWAIT: begin
        if (halt_wb && advance)      state_d = HALT;
        else if (dhit || !dmemreq)   state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALT);
    if (active && (!advance || lu_stall) && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // State register with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= RUN;
      halted_q      <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      halted_q      <= halted_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign halted      = halted_q;
  assign stall_count = stall_count_q;

endmodule
